// File: rtl/pic_inta_seq.sv
// -----------------------------------------------------------------------------
// pic_inta_seq
//
// CPU-side acknowledge sequencer for an 8259-compatible PIC.
//   * Takes masked requests from the IRR stage and raises int_out when the best
//     pending level outranks everything currently in service (fixed priority,
//     IR0 highest, fully nested).
//   * Runs the two-pulse 8086 INTA cycle:
//       - The first pulse latches the winner, sets isr[winner] and pulses
//         irq_clear[winner].
//       - The second pulse drives {vector_base, winner} onto the data bus.
//   * Retires in-service levels on specific or non-specific EOI commands.
//
// Build option:
//   AUTO_EOI_EN  When defined, isr[winner] is cleared on the rising edge that
//                ends the second INTA pulse. Explicit EOIs still work.
//                When undefined, the in-service bit is held until an EOI.
//
// Parameters:
//   ACK_TIMEOUT   Number of clk cycles allowed between the end of the first
//                 INTA pulse and the start of the second (1..255).
//
// Ports:
//   clk           System clock. All logic is on the rising edge.
//   rst           Synchronous reset, active-high.
//   irr[7:0]      Pending requests from the IRR stage.
//   imr[7:0]      Interrupt mask (1 = masked).
//   vector_base   ICW2 bits T7..T3.
//   inta_n        CPU interrupt acknowledge, active-low, already synchronised.
//   eoi_valid     One-cycle EOI command strobe.
//   eoi_specific  1 = specific EOI, 0 = non-specific EOI.
//   eoi_level     Level cleared by a specific EOI.
//   int_out       Interrupt request to the CPU.
//   isr[7:0]      In-Service Register.
//   irq_clear     One-hot, one-cycle pulse that drops the IRR edge latch.
//   data_out      Vector byte (holds the last vector while data_oe is 0).
//   data_oe       Data bus drive enable.
//   ack_error     One-cycle pulse when the second INTA pulse times out.
// -----------------------------------------------------------------------------
module pic_inta_seq #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       inta_n,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irq_clear,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ack_error
);

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_ACK2  = 3'd4
  } state_t;

  // Index of the lowest set bit; 8 means "no bit set". This is also the
  // natural "no ceiling" value for the nesting comparison.
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot decode of a 4-bit index; index 8 (bit 3 set) decodes to zero.
  function automatic logic [7:0] idx_onehot(input logic [3:0] idx);
    logic [7:0] v;
    if (idx[3]) begin
      v = 8'h00;
    end else begin
      v = 8'h01 << idx[2:0];
    end
    return v;
  endfunction

  state_t     state_q, state_d;
  logic       inta_q, inta_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] winner_q, winner_d;
  logic       spurious_q, spurious_d;
  logic       ack1_entry_q, ack1_entry_d;
  logic       int_out_q, int_out_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] irq_clear_q, irq_clear_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       ack_error_q, ack_error_d;

  logic [7:0] eligible_s;
  logic [3:0] cand_idx_s;
  logic [3:0] ceil_idx_s;
  logic       req_valid_s;
  logic       fall_s;
  logic       rise_s;
  logic [7:0] eoi_clr_s;
  logic [7:0] auto_clr_s;
  logic [7:0] isr_set_s;

  // Request qualification, INTA edge detection and EOI clear mask
  always_comb begin
    eligible_s  = irr & ~imr;
    cand_idx_s  = lowest_idx(eligible_s);
    ceil_idx_s  = lowest_idx(isr_q);
    // cand_idx_s is 8 when nothing is eligible, which is never below a ceiling.
    req_valid_s = (cand_idx_s < ceil_idx_s);
    fall_s      = inta_q & ~inta_n;
    rise_s      = ~inta_q & inta_n;
    eoi_clr_s   = 8'h00;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clr_s = idx_onehot({1'b0, eoi_level});
      end else begin
        // Non-specific EOI retires the highest-priority level in service.
        eoi_clr_s = idx_onehot(ceil_idx_s);
      end
    end else begin
      eoi_clr_s = 8'h00;
    end
  end

  // Acknowledge FSM: next state and registered-output next values
  always_comb begin
    state_d      = state_q;
    inta_d       = inta_n;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    spurious_d   = spurious_q;
    ack1_entry_d = 1'b0;
    int_out_d    = 1'b0;
    irq_clear_d  = 8'h00;
    data_out_d   = data_out_q;
    data_oe_d    = 1'b0;
    ack_error_d  = 1'b0;
    isr_set_s    = 8'h00;
    auto_clr_s   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        // A falling INTA edge here is deliberately ignored.
        if (req_valid_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // The CPU has committed once it pulls INTA low. Go on to ACK1 even if
        // the request vanished in the same cycle; ACK1 then reports spurious.
        if (fall_s) begin
          state_d      = ST_ACK1;
          ack1_entry_d = 1'b1;
        end else if (!req_valid_s) begin
          state_d = ST_IDLE;
        end else begin
          int_out_d = 1'b1;
        end
      end

      ST_ACK1: begin
        if (ack1_entry_q) begin
          if (req_valid_s) begin
            winner_d    = cand_idx_s[2:0];
            spurious_d  = 1'b0;
            isr_set_s   = idx_onehot(cand_idx_s);
            irq_clear_d = idx_onehot(cand_idx_s);
          end else begin
            // Spurious acknowledge: report IR7 without touching the ISR.
            winner_d   = 3'd7;
            spurious_d = 1'b1;
          end
        end else begin
          winner_d = winner_q;
        end
        if (rise_s) begin
          state_d = ST_WAIT2;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_ACK1;
        end
      end

      ST_WAIT2: begin
        // A fall in the same cycle as the timeout still counts as on time.
        if (fall_s) begin
          state_d = ST_ACK2;
          cnt_d   = 8'd0;
        end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
          state_d     = ST_IDLE;
          cnt_d       = 8'd0;
          ack_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_ACK2: begin
        if (rise_s) begin
          state_d   = ST_IDLE;
          data_oe_d = 1'b0;
`ifdef AUTO_EOI_EN
          // Release the nesting ceiling as soon as the vector has been read.
          if (!spurious_q) begin
            auto_clr_s = idx_onehot({1'b0, winner_q});
          end else begin
            auto_clr_s = 8'h00;
          end
`else
          auto_clr_s = 8'h00;
`endif
        end else begin
          data_oe_d  = 1'b1;
          data_out_d = {vector_base, winner_q};
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // EOI clears are taken from the pre-cycle ISR. The ACK1 set is applied
    // last, so it wins if both hit the same bit.
    isr_d = (isr_q & ~eoi_clr_s & ~auto_clr_s) | isr_set_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inta_q       <= 1'b1;
      cnt_q        <= 8'd0;
      winner_q     <= 3'd0;
      spurious_q   <= 1'b0;
      ack1_entry_q <= 1'b0;
      int_out_q    <= 1'b0;
      isr_q        <= 8'h00;
      irq_clear_q  <= 8'h00;
      data_out_q   <= 8'h00;
      data_oe_q    <= 1'b0;
      ack_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inta_q       <= inta_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      spurious_q   <= spurious_d;
      ack1_entry_q <= ack1_entry_d;
      int_out_q    <= int_out_d;
      isr_q        <= isr_d;
      irq_clear_q  <= irq_clear_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      ack_error_q  <= ack_error_d;
    end
  end

  assign int_out   = int_out_q;
  assign isr       = isr_q;
  assign irq_clear = irq_clear_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_pic_inta_seq.sv
// -----------------------------------------------------------------------------
// tb_pic_inta_seq
//
// Self-checking bench for pic_inta_seq.
//   * Directed scenarios come first: reset, basic acknowledge, nesting, spurious
//     acknowledge, timeout, EOI/ACK1 collision and reset mid-sequence.
//   * A randomized loop follows.
//   * Expectations come from a transaction-level model: the ISR contents, the
//     winner rule and the vector byte.
// -----------------------------------------------------------------------------
module tb_pic_inta_seq;

  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       inta_n;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irq_clear;
  logic [7:0] data_out;
  logic       data_oe;
  logic       ack_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_isr;
  logic [7:0] m_last_vec;

  pic_inta_seq #(.ACK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .irr          (irr),
    .imr          (imr),
    .vector_base  (vector_base),
    .inta_n       (inta_n),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .int_out      (int_out),
    .isr          (isr),
    .irq_clear    (irq_clear),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .ack_error    (ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: priority position of the highest-priority bit (8 when empty).
  function automatic int m_lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 8;
  endfunction

  function automatic logic [7:0] m_bit(input int i);
    logic [7:0] r;
    r = 8'h00;
    if (i < 8) r[i] = 1'b1;
    return r;
  endfunction

  task automatic do_eoi(input bit spec, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_specific = spec;
    eoi_level = lvl;
    step();
    eoi_valid = 1'b0;
    if (spec) m_isr = m_isr & ~m_bit(int'(lvl));
    else      m_isr = m_isr & ~m_bit(m_lowest(m_isr));
    check_eq("isr_after_eoi", {24'h0, isr}, {24'h0, m_isr});
  endtask

  // One complete request/acknowledge transaction starting from IDLE.
  task automatic run_ack(input logic [7:0] irr_v, input logic [7:0] imr_v,
                         input bit second, input int gap, input int hold,
                         input bit eoi_now, input bit eoi_spec_v,
                         input logic [2:0] eoi_lvl_v, input bit drop);
    int cand;
    int ceil_i;
    int win;
    bit spur;
    logic [7:0] clr;
    logic [7:0] set;
    logic [7:0] vec;

    ceil_i = m_lowest(m_isr);
    cand   = m_lowest(irr_v & ~imr_v);
    irr = irr_v;
    imr = imr_v;
    if (!(cand < ceil_i)) begin
      for (int k = 0; k < 3; k++) begin
        step();
        check_eq("no_req_int_out", {31'h0, int_out}, 32'h0);
      end
      irr = 8'h00;
      step();
      return;
    end
    step();
    check_eq("int_out_latency", {31'h0, int_out}, 32'h0);
    step();
    check_eq("int_out_req", {31'h0, int_out}, 32'h1);

    // First INTA pulse.
    inta_n = 1'b0;
    if (drop) irr = 8'h00;
    step();
    if (eoi_now) begin
      eoi_valid = 1'b1;
      eoi_specific = eoi_spec_v;
      eoi_level = eoi_lvl_v;
    end
    cand = m_lowest(irr & ~imr);
    spur = !(cand < ceil_i);
    win  = spur ? 7 : cand;
    set  = spur ? 8'h00 : m_bit(win);
    clr  = 8'h00;
    if (eoi_now) clr = eoi_spec_v ? m_bit(int'(eoi_lvl_v)) : m_bit(m_lowest(m_isr));
    m_isr = (m_isr & ~clr) | set;
    step();
    eoi_valid = 1'b0;
    check_eq("isr_ack1", {24'h0, isr}, {24'h0, m_isr});
    check_eq("irq_clear_set", {24'h0, irq_clear}, {24'h0, set});
    check_eq("int_out_ack1", {31'h0, int_out}, 32'h0);
    irr = irr & ~set;
    inta_n = 1'b1;
    step();
    check_eq("irq_clear_pulse", {24'h0, irq_clear}, 32'h0);

    if (second) begin
      for (int k = 0; k < gap; k++) begin
        step();
        check_eq("no_early_err", {31'h0, ack_error}, 32'h0);
      end
      inta_n = 1'b0;
      step();
      vec = {vector_base, 3'(win)};
      for (int k = 0; k <= hold; k++) begin
        step();
        check_eq("data_oe_ack2", {31'h0, data_oe}, 32'h1);
        check_eq("vector", {24'h0, data_out}, {24'h0, vec});
      end
      inta_n = 1'b1;
      irr = 8'h00;
      step();
      m_last_vec = vec;
      check_eq("data_oe_off", {31'h0, data_oe}, 32'h0);
      check_eq("vector_hold", {24'h0, data_out}, {24'h0, m_last_vec});
`ifdef AUTO_EOI_EN
      if (!spur) m_isr = m_isr & ~m_bit(win);
`endif
      check_eq("isr_after_ack2", {24'h0, isr}, {24'h0, m_isr});
      check_eq("ack_error_ok", {31'h0, ack_error}, 32'h0);
    end else begin
      irr = 8'h00;
      for (int k = 0; k < T - 1; k++) begin
        step();
        check_eq("timeout_early", {31'h0, ack_error}, 32'h0);
      end
      step();
      check_eq("timeout_pulse", {31'h0, ack_error}, 32'h1);
      step();
      check_eq("timeout_one_cycle", {31'h0, ack_error}, 32'h0);
      check_eq("isr_timeout", {24'h0, isr}, {24'h0, m_isr});
      check_eq("data_oe_timeout", {31'h0, data_oe}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    irr = 8'h00;
    imr = 8'h00;
    vector_base = 5'h00;
    inta_n = 1'b1;
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    eoi_level = 3'd0;
    m_isr = 8'h00;
    m_last_vec = 8'h00;

    // Reset.
    step();
    step();
    check_eq("rst_int_out", {31'h0, int_out}, 32'h0);
    check_eq("rst_isr", {24'h0, isr}, 32'h0);
    check_eq("rst_irq_clear", {24'h0, irq_clear}, 32'h0);
    check_eq("rst_data_out", {24'h0, data_out}, 32'h0);
    check_eq("rst_data_oe", {31'h0, data_oe}, 32'h0);
    check_eq("rst_ack_error", {31'h0, ack_error}, 32'h0);
    rst = 1'b0;
    step();

    // Basic acknowledge: IR2 wins over IR5, vector 8'h8A.
    vector_base = 5'h11;
    run_ack(8'h24, 8'h00, 1'b1, 1, 0, 1'b0, 1'b0, 3'd0, 1'b0);
    check_eq("basic_vector", {24'h0, data_out}, 32'h8A);
    check_eq("basic_isr", {24'h0, isr}, 32'h04);

    // Nesting: IR3 is blocked behind IR2; IR1 preempts.
    run_ack(8'h08, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0);
    run_ack(8'h0A, 8'h00, 1'b1, 2, 1, 1'b0, 1'b0, 3'd0, 1'b0);
    check_eq("nest_isr", {24'h0, isr}, 32'h06);
    do_eoi(1'b0, 3'd0);
    check_eq("nest_eoi_isr", {24'h0, isr}, 32'h04);
    do_eoi(1'b1, 3'd2);

    // Request withdrawn while in REQ: int_out drops.
    irr = 8'h10;
    step();
    step();
    check_eq("withdraw_int_hi", {31'h0, int_out}, 32'h1);
    irr = 8'h00;
    step();
    check_eq("withdraw_int_lo", {31'h0, int_out}, 32'h0);
    step();

    // Spurious acknowledge.
    run_ack(8'h10, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b1);
    check_eq("spurious_vector", {24'h0, data_out}, 32'h8F);

    // Second INTA pulse never arrives.
    run_ack(8'h04, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Same-cycle specific EOI and ACK1 set on IR0: the set wins.
    run_ack(8'h01, 8'h00, 1'b1, 3, 0, 1'b1, 1'b1, 3'd0, 1'b0);
    do_eoi(1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);

    // Reset in the middle of an acknowledge, with INTA still low.
    irr = 8'h02;
    step();
    step();
    inta_n = 1'b0;
    step();
    step();
    rst = 1'b1;
    irr = 8'h00;
    step();
    check_eq("midrst_isr", {24'h0, isr}, 32'h0);
    check_eq("midrst_int_out", {31'h0, int_out}, 32'h0);
    check_eq("midrst_irq_clear", {24'h0, irq_clear}, 32'h0);
    rst = 1'b0;
    m_isr = 8'h00;
    m_last_vec = 8'h00;
    step();
    step();
    check_eq("idle_fall_isr", {24'h0, isr}, 32'h0);
    check_eq("idle_fall_int", {31'h0, int_out}, 32'h0);
    check_eq("idle_fall_oe", {31'h0, data_oe}, 32'h0);
    inta_n = 1'b1;
    step();

    // Randomized transactions.
    for (int it = 0; it < 60; it++) begin
      vector_base = 5'($urandom_range(0, 31));
      run_ack(8'($urandom_range(0, 255)), 8'($urandom & $urandom),
              ($urandom_range(0, 7) != 0), $urandom_range(0, T - 1),
              $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 9) < 6) begin
        do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      check_eq("rand_isr", {24'h0, isr}, {24'h0, m_isr});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
